// File: rtl/present_dm_chain_if.sv
// ---------------------------------------------------------------------------
// present_dm_chain_if
//   Block-side and result-side signals of the PRESENT Davies-Meyer engine.
//
//   Handshake semantics (both sides):
//     - A block is taken on a rising clk edge where iValid && oReady.
//       iDat/iKey/iMode/iChain/iFirst are sampled only on that edge.
//       iValid while oReady=0 is ignored, not queued.
//     - A result is handed over on a rising clk edge where oValid && iOutReady.
//       oDat is held stable while oValid=1 and iOutReady=0.
//
//   Signals:
//     iValid, iDat[63:0], iKey[KEY_W-1:0], iMode, iChain, iFirst : block in
//     oReady                                                     : can accept
//     oValid, oDat[63:0], iOutReady                              : result out
//     oH[63:0]                                                   : chain register
//     oState[1:0]                                                : FSM state (debug)
//   Modports: master = hash controller side, slave = engine side.
// ---------------------------------------------------------------------------
interface present_dm_chain_if #(
    parameter int KEY_W = 80
);
    logic             iValid;
    logic             oReady;
    logic [63:0]      iDat;
    logic [KEY_W-1:0] iKey;
    logic             iMode;
    logic             iChain;
    logic             iFirst;
    logic             oValid;
    logic             iOutReady;
    logic [63:0]      oDat;
    logic [63:0]      oH;
    logic [1:0]       oState;

    modport master (
        output iValid, iDat, iKey, iMode, iChain, iFirst, iOutReady,
        input  oReady, oValid, oDat, oH, oState
    );

    modport slave (
        input  iValid, iDat, iKey, iMode, iChain, iFirst, iOutReady,
        output oReady, oValid, oDat, oH, oState
    );
endinterface

// File: rtl/present_dm_chain.sv
// ---------------------------------------------------------------------------
// present_dm_chain
//   Iterative PRESENT-64 engine (one round per clock) used as a Davies-Meyer
//   compression function H' = E_K(P) xor P, with an optional plain-encrypt
//   mode and an internal chaining register H for multi-block hashing.
//
//   Parameters:
//     KEY_W   : 80 or 128 (key schedule variant)
//     NROUNDS : 1..31 cipher rounds
//     IV      : chain register value after reset and on iFirst
//
//   Ports:
//     clk    : rising-edge clock
//     iReset : synchronous active-high reset
//     bus    : present_dm_chain_if.slave (block in, result out, oH, oState)
//
//   Latency: oValid rises NROUNDS+1 edges after the accepting edge.
// ---------------------------------------------------------------------------
module present_dm_chain #(
    parameter int          KEY_W   = 80,
    parameter int          NROUNDS = 31,
    parameter logic [63:0] IV      = 64'h0
) (
    input  logic              clk,
    input  logic              iReset,
    present_dm_chain_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FINAL = 2'd2,
        S_OUT   = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Elaboration-time parameter checks
    // ------------------------------------------------------------------
    generate
        if (KEY_W != 80 && KEY_W != 128) begin : g_bad_key_w
            $error("present_dm_chain: KEY_W must be 80 or 128");
        end
        if (NROUNDS < 1 || NROUNDS > 31) begin : g_bad_nrounds
            $error("present_dm_chain: NROUNDS must be in 1..31");
        end
    endgenerate

    function automatic logic [3:0] sbox4(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'hC;  4'h1: y = 4'h5;  4'h2: y = 4'h6;  4'h3: y = 4'hB;
            4'h4: y = 4'h9;  4'h5: y = 4'h0;  4'h6: y = 4'hA;  4'h7: y = 4'hD;
            4'h8: y = 4'h3;  4'h9: y = 4'hE;  4'hA: y = 4'hF;  4'hB: y = 4'h8;
            4'hC: y = 4'h4;  4'hD: y = 4'h7;  4'hE: y = 4'h1;  default: y = 4'h2;
        endcase
        return y;
    endfunction

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t           state_q;
    logic             ready_q;
    logic             valid_q;
    logic [63:0]      odat_q;
    logic [63:0]      h_q;
    logic [4:0]       round_q;
    logic [63:0]      dreg_q;   // cipher state
    logic [63:0]      preg_q;   // plaintext kept for the feed-forward xor
    logic [KEY_W-1:0] kreg_q;   // key register
    logic             mode_q;
    logic             chain_q;  // block was accepted with iChain=1

    // ------------------------------------------------------------------
    // Round datapath
    // ------------------------------------------------------------------
    logic [63:0]      round_key;
    logic [63:0]      sb_out;
    logic [63:0]      perm_out;
    logic [63:0]      cipher;
    logic [63:0]      result_d;
    logic [63:0]      plain_sel;
    logic [KEY_W-1:0] key_next;

    assign round_key = kreg_q[KEY_W-1 -: 64];
    assign cipher    = dreg_q ^ round_key;
    assign result_d  = mode_q ? cipher : (cipher ^ preg_q);
    assign plain_sel = bus.iChain ? (bus.iFirst ? IV : h_q) : bus.iDat;

    always_comb begin
        sb_out   = '0;
        perm_out = '0;
        for (int n = 0; n < 16; n++) begin
            sb_out[4*n +: 4] = sbox4(dreg_q[4*n +: 4] ^ round_key[4*n +: 4]);
        end
        // Bit i moves to 16*i mod 63; the top bit maps onto itself.
        for (int i = 0; i < 63; i++) begin
            perm_out[(16*i) % 63] = sb_out[i];
        end
        perm_out[63] = sb_out[63];
    end

    // Key schedule: rotate left by 61, S-box the top nibble(s), then fold the
    // current round number into a fixed 5-bit window.
    generate
        if (KEY_W == 80) begin : g_key80
            logic [KEY_W-1:0] key_rot;
            assign key_rot  = {kreg_q[18:0], kreg_q[KEY_W-1:19]};
            assign key_next = {sbox4(key_rot[79:76]), key_rot[75:20],
                               key_rot[19:15] ^ round_q, key_rot[14:0]};
        end else begin : g_key128
            logic [KEY_W-1:0] key_rot;
            assign key_rot  = {kreg_q[66:0], kreg_q[KEY_W-1:67]};
            assign key_next = {sbox4(key_rot[127:124]), sbox4(key_rot[123:120]),
                               key_rot[119:67], key_rot[66:62] ^ round_q,
                               key_rot[61:0]};
        end
    endgenerate

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (iReset) begin
            state_q <= S_IDLE;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
            odat_q  <= '0;
            h_q     <= IV;
            round_q <= '0;
            dreg_q  <= '0;
            preg_q  <= '0;
            kreg_q  <= '0;
            mode_q  <= 1'b0;
            chain_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.iValid && ready_q) begin
                        dreg_q  <= plain_sel;
                        preg_q  <= plain_sel;
                        kreg_q  <= bus.iKey;
                        mode_q  <= bus.iMode;
                        chain_q <= bus.iChain;
                        round_q <= 5'd1;
                        if (bus.iChain && bus.iFirst) begin
                            h_q <= IV;
                        end
                        ready_q <= 1'b0;
                        state_q <= S_RUN;
                    end
                end
                S_RUN: begin
                    dreg_q <= perm_out;
                    kreg_q <= key_next;
                    // Stop counting on the last round so the 5-bit counter
                    // never wraps when NROUNDS is 31.
                    if (round_q == 5'(NROUNDS)) begin
                        state_q <= S_FINAL;
                    end else begin
                        round_q <= round_q + 5'd1;
                    end
                end
                S_FINAL: begin
                    odat_q  <= result_d;
                    if (chain_q) begin
                        h_q <= result_d;
                    end
                    valid_q <= 1'b1;
                    state_q <= S_OUT;
                end
                default: begin // S_OUT
                    if (bus.iOutReady) begin
                        valid_q <= 1'b0;
                        ready_q <= 1'b1;
                        state_q <= S_IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.oReady = ready_q;
    assign bus.oValid = valid_q;
    assign bus.oDat   = odat_q;
    assign bus.oH     = h_q;
    assign bus.oState = state_q;

endmodule

// File: tb/tb_present_dm_chain.sv
// ---------------------------------------------------------------------------
// tb_present_dm_chain
//   Bench for present_dm_chain: an 80-bit-key instance (IV=0) and a
//   128-bit-key instance (non-zero IV) share one clock and reset.
//   Known-answer vectors, chaining, handshake corners, mid-run reset and
//   random blocks checked against a behavioural PRESENT model.
// ---------------------------------------------------------------------------
module tb_present_dm_chain;

    localparam int          NR      = 31;
    localparam logic [63:0] IV80    = 64'h0;
    localparam logic [63:0] IV128   = 64'h0123456789abcdef;

    logic clk;
    logic rst;

    int n_checks = 0;
    int n_err    = 0;

    logic [63:0] h80_model;
    logic [63:0] h128_model;

    logic [3:0] sbox_tab [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                                  4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};

    present_dm_chain_if #(.KEY_W(80))  bus80 ();
    present_dm_chain_if #(.KEY_W(128)) bus128 ();

    present_dm_chain #(.KEY_W(80), .NROUNDS(NR), .IV(IV80)) dut80 (
        .clk    (clk),
        .iReset (rst),
        .bus    (bus80.slave)
    );

    present_dm_chain #(.KEY_W(128), .NROUNDS(NR), .IV(IV128)) dut128 (
        .clk    (clk),
        .iReset (rst),
        .bus    (bus128.slave)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [63:0] present_ref(input logic [63:0] pt,
                                                input logic [127:0] key,
                                                input bit wide);
        logic [63:0]  s;
        logic [63:0]  t;
        logic [63:0]  rk;
        logic [127:0] k;
        logic [79:0]  k80;
        s   = pt;
        k   = key;
        k80 = key[79:0];
        for (int r = 1; r <= NR; r++) begin
            rk = wide ? k[127:64] : k80[79:16];
            s  = s ^ rk;
            for (int n = 0; n < 16; n++) s[4*n +: 4] = sbox_tab[s[4*n +: 4]];
            t = '0;
            for (int i = 0; i < 64; i++) t[(i == 63) ? 63 : (i * 16) % 63] = s[i];
            s = t;
            if (wide) begin
                k = (k << 61) | (k >> 67);
                k[127:124] = sbox_tab[k[127:124]];
                k[123:120] = sbox_tab[k[123:120]];
                k[66:62]   = k[66:62] ^ 5'(r);
            end else begin
                k80 = (k80 << 61) | (k80 >> 19);
                k80[79:76] = sbox_tab[k80[79:76]];
                k80[19:15] = k80[19:15] ^ 5'(r);
            end
        end
        rk = wide ? k[127:64] : k80[79:16];
        return s ^ rk;
    endfunction

    // Expected result of one block; updates the modelled chain register.
    function automatic logic [63:0] model_block(input bit s, input logic [63:0] d,
                                                input logic [127:0] k, input logic m,
                                                input logic c, input logic f);
        logic [63:0] p;
        logic [63:0] e;
        logic [63:0] r;
        if (c) p = f ? (s ? IV128 : IV80) : (s ? h128_model : h80_model);
        else   p = d;
        e = present_ref(p, k, s);
        r = m ? e : (e ^ p);
        if (c) begin
            if (s) h128_model = r;
            else   h80_model  = r;
        end
        return r;
    endfunction

    // ---------------- helpers ----------------
    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic get_ready(input bit s);
        return s ? bus128.oReady : bus80.oReady;
    endfunction
    function automatic logic get_valid(input bit s);
        return s ? bus128.oValid : bus80.oValid;
    endfunction
    function automatic logic [63:0] get_dat(input bit s);
        return s ? bus128.oDat : bus80.oDat;
    endfunction
    function automatic logic [63:0] get_h(input bit s);
        return s ? bus128.oH : bus80.oH;
    endfunction

    task automatic drive(input bit s, input logic v, input logic [63:0] d,
                         input logic [127:0] k, input logic m, input logic c,
                         input logic f, input logic ordy);
        if (s) begin
            bus128.iValid = v; bus128.iDat = d; bus128.iKey = k;
            bus128.iMode = m; bus128.iChain = c; bus128.iFirst = f;
            bus128.iOutReady = ordy;
        end else begin
            bus80.iValid = v; bus80.iDat = d; bus80.iKey = k[79:0];
            bus80.iMode = m; bus80.iChain = c; bus80.iFirst = f;
            bus80.iOutReady = ordy;
        end
    endtask

    task automatic drive_junk(input bit s, input logic v);
        drive(s, v, {$urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom},
              1'($urandom), 1'($urandom), 1'($urandom), 1'b0);
    endtask

    // Accept one block, wait for the result, hold it for 'hold' cycles, then
    // consume it. With 'pulse' set, iValid stays high with junk during RUN/OUT.
    task automatic do_block(input bit s, input logic [63:0] d, input logic [127:0] k,
                            input logic m, input logic c, input logic f,
                            input int hold, input bit pulse,
                            output logic [63:0] res);
        int w;
        int lat;
        w = 0;
        while (!get_ready(s) && w < 50) begin
            @(posedge clk); #1; w++;
        end
        check("ready_before_accept", 64'(get_ready(s)), 64'd1);
        drive(s, 1'b1, d, k, m, c, f, 1'b0);
        @(posedge clk); #1;
        drive_junk(s, pulse);
        lat = 0;
        while (!get_valid(s) && lat < 100) begin
            @(posedge clk); #1;
            lat++;
            if (lat == 5) check("busy_ready_low", 64'(get_ready(s)), 64'd0);
        end
        check("latency", 64'(lat), 64'(NR + 1));
        res = get_dat(s);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("hold_dat_stable", get_dat(s), res);
            check("hold_valid", 64'(get_valid(s)), 64'd1);
            check("hold_ready_low", 64'(get_ready(s)), 64'd0);
        end
        drive(s, 1'b0, 64'h0, 128'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        @(posedge clk); #1;
        drive(s, 1'b0, 64'h0, 128'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("consume_valid_low", 64'(get_valid(s)), 64'd0);
        check("consume_ready_high", 64'(get_ready(s)), 64'd1);
    endtask

    // ---------------- known-answer table (80-bit instance) ----------------
    typedef struct {
        logic [63:0] dat;
        logic [79:0] key;
        logic        mode;
        logic        chain;
        logic        first;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs [6];

    initial begin
        logic [63:0] res;
        logic [63:0] exp;
        logic [63:0] d;
        logic [127:0] k;
        logic m, c, f;
        bit s;
        int lat;

        drive(1'b0, 1'b0, 64'h0, 128'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 64'h0, 128'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        h80_model  = IV80;
        h128_model = IV128;

        // Chained block 2 expected value comes from the model, not a constant.
        vecs[0] = '{64'h0, 80'h0, 1'b1, 1'b0, 1'b0, 64'h5579c1387b228445};
        vecs[1] = '{64'hffffffffffffffff, {80{1'b1}}, 1'b1, 1'b0, 1'b0, 64'h3333dcd3213210d2};
        vecs[2] = '{64'hffffffffffffffff, 80'h0, 1'b0, 1'b0, 1'b0, 64'h5eed0038d097be84};
        vecs[3] = '{64'hdeadbeefcafef00d, 80'h0, 1'b1, 1'b1, 1'b1, 64'h5579c1387b228445};
        vecs[4] = '{64'h1234567812345678, 80'h0, 1'b0, 1'b1, 1'b0,
                    present_ref(64'h5579c1387b228445, 128'h0, 1'b0) ^ 64'h5579c1387b228445};
        vecs[5] = '{64'h0, 80'h0, 1'b1, 1'b0, 1'b0, 64'h5579c1387b228445};

        // ---- reset ----
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_ready80", 64'(bus80.oReady), 64'd1);
        check("rst_valid80", 64'(bus80.oValid), 64'd0);
        check("rst_dat80",   bus80.oDat, 64'h0);
        check("rst_h80",     bus80.oH, IV80);
        check("rst_h128",    bus128.oH, IV128);
        check("rst_ready128", 64'(bus128.oReady), 64'd1);

        // ---- table vectors ----
        for (int i = 0; i < 6; i++) begin
            exp = model_block(1'b0, vecs[i].dat, {48'h0, vecs[i].key}, vecs[i].mode,
                              vecs[i].chain, vecs[i].first);
            do_block(1'b0, vecs[i].dat, {48'h0, vecs[i].key}, vecs[i].mode,
                     vecs[i].chain, vecs[i].first, (i == 0) ? 10 : 1, i < 2, res);
            check($sformatf("vec%0d_dat", i), res, vecs[i].exp);
            check($sformatf("vec%0d_h", i), bus80.oH, h80_model);
            // No queued block may appear after a pulsed iValid.
            if (i < 2) begin
                repeat (3) begin
                    @(posedge clk); #1;
                    check("no_queued_block", 64'(bus80.oValid), 64'd0);
                end
            end
        end

        // ---- 128-bit known answer ----
        do_block(1'b1, 64'h0, 128'h0, 1'b1, 1'b0, 1'b0, 1, 1'b0, res);
        check("kat128", res, 64'h96db702a2e6900af);

        // ---- 128-bit chaining from non-zero IV ----
        exp = model_block(1'b1, 64'h0, 128'h55, 1'b0, 1'b1, 1'b1);
        do_block(1'b1, 64'hffff, 128'h55, 1'b0, 1'b1, 1'b1, 2, 1'b0, res);
        check("chain128_first", res, exp);
        check("chain128_h", bus128.oH, h128_model);

        // ---- randomized blocks on both instances ----
        for (int i = 0; i < 30; i++) begin
            s = 1'($urandom_range(0, 1));
            d = {$urandom, $urandom};
            k = {$urandom, $urandom, $urandom, $urandom};
            if (!s) k[127:80] = '0;
            m = 1'($urandom_range(0, 1));
            c = 1'($urandom_range(0, 1));
            f = ($urandom_range(0, 3) == 0);
            exp = model_block(s, d, k, m, c, f);
            do_block(s, d, k, m, c, f, $urandom_range(0, 3), 1'($urandom_range(0, 1)), res);
            check("rand_dat", res, exp);
            check("rand_h", get_h(s), s ? h128_model : h80_model);
        end

        // ---- reset in the middle of a run ----
        while (!bus80.oReady) begin
            @(posedge clk); #1;
        end
        drive(1'b0, 1'b1, 64'h0, 128'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 64'h0, 128'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (14) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        h80_model  = IV80;
        h128_model = IV128;
        check("abort_valid", 64'(bus80.oValid), 64'd0);
        check("abort_dat",   bus80.oDat, 64'h0);
        check("abort_h",     bus80.oH, IV80);
        check("abort_ready", 64'(bus80.oReady), 64'd1);
        lat = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (bus80.oValid) lat++;
        end
        check("abort_no_result", 64'(lat), 64'd0);

        exp = model_block(1'b0, 64'h0, 128'h0, 1'b1, 1'b1, 1'b0);
        do_block(1'b0, 64'habcd, 128'h0, 1'b1, 1'b1, 1'b0, 1, 1'b0, res);
        check("post_abort_dat", res, exp);
        check("post_abort_h", bus80.oH, h80_model);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
